// File: rtl/rx_frame_writer.sv
// Packs the MAC receive byte stream little-endian into buffer words, writes them into
// the current rx slot and commits good frames; errored, oversize or slot-less frames are counted.
module rx_frame_writer #(
    parameter int data_width_p = 64,
    parameter int els_p        = 2048,
    parameter int size_width_p = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_v_i,
    input  logic                      rx_last_i,
    input  logic                      rx_err_i,
    output logic                      rx_ready_o,
    output logic                      write_slot_v_o,
    input  logic                      write_slot_ready_and_i,
    output logic                      write_size_v_o,
    output logic [size_width_p-1:0]   write_size_o,
    output logic                      write_v_o,
    output logic [$clog2(els_p)-1:0]  write_addr_o,
    output logic [data_width_p-1:0]   write_data_o,
    output logic [size_width_p-1:0]   drop_count_o
);

    localparam int W  = data_width_p / 8;
    localparam int LW = $clog2(W);
    localparam int AW = $clog2(els_p);
    localparam int CW = AW + 1;

    // state  | meaning
    // IDLE   | waiting for the first byte of a frame
    // RECV   | storing bytes into the slot
    // FLUSH  | final word write of a good frame on the outputs
    // COMMIT | size and slot strobes
    // DROP   | discarding the rest of a rejected frame
    typedef enum logic [2:0] {IDLE, RECV, FLUSH, COMMIT, DROP} state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [data_width_p-1:0] pack_q, pack_d;
    logic [size_width_p-1:0] drop_q, drop_d;
    logic                    wr_v_q, wr_v_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [data_width_p-1:0] wr_data_q, wr_data_d;

    logic [CW-1:0]           cnt_cur;
    logic [LW-1:0]           lane;
    logic [data_width_p-1:0] pack_nxt;
    logic                    accept;
    logic                    store;
    logic                    drop_inc;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            pack_q     <= '0;
            drop_q     <= '0;
            wr_v_q     <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            drop_q     <= drop_d;
            wr_v_q     <= wr_v_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        drop_d     = drop_q;
        wr_v_d     = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        store      = 1'b0;
        drop_inc   = 1'b0;
        accept     = rx_v_i & rx_ready_o;
        // the first byte of a frame is handled as byte 0 of RECV
        cnt_cur    = (state_q == IDLE) ? '0 : byte_cnt_q;
        lane       = cnt_cur[LW-1:0];
        pack_nxt   = pack_q;
        for (int i = 0; i < W; i++) begin
            if (lane == LW'(i)) pack_nxt[8*i +: 8] = rx_data_i;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (write_slot_ready_and_i) store = 1'b1;
                    else if (rx_last_i)        drop_inc = 1'b1;
                    else                       state_d = DROP;
                end
            end
            RECV: begin
                if (accept) begin
                    if (byte_cnt_q == CW'(els_p)) begin
                        pack_d = '0;
                        if (rx_last_i) begin
                            drop_inc = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = DROP;
                        end
                    end else begin
                        store = 1'b1;
                    end
                end
            end
            FLUSH:  state_d = COMMIT;
            COMMIT: state_d = IDLE;
            DROP: begin
                if (accept && rx_last_i) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (store) begin
            byte_cnt_d = cnt_cur + 1'b1;
            state_d    = RECV;
            if (lane == LW'(W - 1) || rx_last_i) begin
                wr_v_d    = 1'b1;
                wr_addr_d = {cnt_cur[AW-1:LW], {LW{1'b0}}};
                wr_data_d = pack_nxt;
                pack_d    = '0;
            end else begin
                pack_d    = pack_nxt;
            end
            if (rx_last_i) begin
                if (rx_err_i) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else begin
                    state_d  = FLUSH;
                end
            end
        end

        if (drop_inc && drop_q != '1) drop_d = drop_q + 1'b1;
        if (state_d == IDLE) byte_cnt_d = '0;
    end

    always_comb begin
        rx_ready_o     = (state_q == IDLE) || (state_q == RECV) || (state_q == DROP);
        write_size_v_o = (state_q == COMMIT);
        write_slot_v_o = (state_q == COMMIT);
        write_size_o   = (state_q == COMMIT) ? size_width_p'(byte_cnt_q) : '0;
        write_v_o      = wr_v_q;
        write_addr_o   = wr_addr_q;
        write_data_o   = wr_data_q;
        drop_count_o   = drop_q;
    end

`ifndef SYNTHESIS
    a_width: assert property (@(posedge clk_i) (data_width_p == 32) || (data_width_p == 64));
    a_align: assert property (@(posedge clk_i) disable iff (reset_i)
                              write_v_o |-> (write_addr_o[LW-1:0] == '0));
    a_size:  assert property (@(posedge clk_i) disable iff (reset_i)
                              write_size_v_o |-> (write_size_o != '0));
    a_slot:  assert property (@(posedge clk_i) disable iff (reset_i)
                              (state_q == COMMIT) |-> write_slot_ready_and_i);
`endif

endmodule

// File: tb/tb_rx_frame_writer.sv
// Directed frames for rx_frame_writer; expected writes/commits are queued at issue time
// and popped by a monitor that watches the write and commit strobes.
module tb_rx_frame_writer;

    localparam int ELS = 2048;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  rx_data_i;
    logic        rx_v_i;
    logic        rx_last_i;
    logic        rx_err_i;
    logic        rx_ready_o;
    logic        write_slot_v_o;
    logic        write_slot_ready_and_i;
    logic        write_size_v_o;
    logic [15:0] write_size_o;
    logic        write_v_o;
    logic [10:0] write_addr_o;
    logic [63:0] write_data_o;
    logic [15:0] drop_count_o;

    rx_frame_writer #(.data_width_p(64), .els_p(ELS), .size_width_p(16)) dut (
        .clk_i                  (clk_i),
        .reset_i                (reset_i),
        .rx_data_i              (rx_data_i),
        .rx_v_i                 (rx_v_i),
        .rx_last_i              (rx_last_i),
        .rx_err_i               (rx_err_i),
        .rx_ready_o             (rx_ready_o),
        .write_slot_v_o         (write_slot_v_o),
        .write_slot_ready_and_i (write_slot_ready_and_i),
        .write_size_v_o         (write_size_v_o),
        .write_size_o           (write_size_o),
        .write_v_o              (write_v_o),
        .write_addr_o           (write_addr_o),
        .write_data_o           (write_data_o),
        .drop_count_o           (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          is_commit;
        logic [10:0] addr;
        logic [63:0] data;
        logic [15:0] size;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_drop = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          wr_count = 0;
    logic [63:0] first_data;
    logic [63:0] last_data;
    logic [10:0] last_addr;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                if (write_v_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", {53'd0, write_addr_o}, 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_kind", {63'd0, e.is_commit}, 64'd0);
                        check("write_addr", {53'd0, write_addr_o}, {53'd0, e.addr});
                        check("write_data", write_data_o, e.data);
                    end
                    if (wr_count == 0) first_data = write_data_o;
                    last_data   = write_data_o;
                    last_addr   = write_addr_o;
                    last_wr_cyc = cyc;
                    wr_count++;
                end
                if (write_size_v_o || write_slot_v_o) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_commit", {48'd0, write_size_o}, 64'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("commit_kind", {63'd0, e.is_commit}, 64'd1);
                        check("commit_size", {48'd0, write_size_o}, {48'd0, e.size});
                        check("commit_strobes", {62'd0, write_size_v_o, write_slot_v_o}, 64'd3);
                        check("commit_gap", 64'(cyc - last_wr_cyc), 64'd1);
                    end
                end
            end
        end
    endtask

    task automatic push_frame(input int len, input bit err, input bit slot,
                              input logic [7:0] base, input int abort_at);
        exp_t e;
        int   stored;
        if (!slot) begin
            exp_drop++;
            return;
        end
        stored = (len > ELS) ? ELS : len;
        if (abort_at > 0) stored = (abort_at / 8) * 8;
        for (int w = 0; w * 8 < stored; w++) begin
            e.is_commit = 1'b0;
            e.addr      = 11'(w * 8);
            e.data      = '0;
            e.size      = '0;
            for (int b = 0; b < 8 && (w * 8 + b) < stored; b++)
                e.data[8*b +: 8] = base + 8'(w * 8 + b);
            exp_q.push_back(e);
        end
        if (abort_at > 0) return;
        if (err || len > ELS) begin
            exp_drop++;
        end else begin
            e.is_commit = 1'b1;
            e.addr      = '0;
            e.data      = '0;
            e.size      = 16'(len);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int len, input bit err, input bit slot,
                              input logic [7:0] base, input int gap_mod, input int abort_at);
        int n;
        int nbytes;
        push_frame(len, err, slot, base, abort_at);
        wr_count = 0;
        nbytes = (abort_at > 0) ? abort_at : len;
        write_slot_ready_and_i = slot;
        for (int k = 0; k < nbytes; k++) begin
            if (gap_mod != 0 && (k % gap_mod) == 1) begin
                rx_v_i    = 1'b0;
                rx_data_i = 8'hFF;
                rx_last_i = 1'b1;
                rx_err_i  = 1'b1;
                @(posedge clk_i); #1;
            end
            rx_v_i    = 1'b1;
            rx_data_i = base + 8'(k);
            rx_last_i = (abort_at == 0) && (k == len - 1);
            rx_err_i  = err && (k == len - 1);
            if (k == 0) begin
                n = 0;
                while (rx_ready_o !== 1'b1 && n < 20) begin
                    @(posedge clk_i); #1;
                    n++;
                end
                check("ready_wait", {63'd0, n < 20}, 64'd1);
            end
            @(posedge clk_i); #1;
            write_slot_ready_and_i = 1'b1;
        end
        rx_v_i    = 1'b0;
        rx_last_i = 1'b0;
        rx_err_i  = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk_i);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("drop_count", {48'd0, drop_count_o}, 64'(exp_drop));
    endtask

    initial begin
        reset_i = 1'b1;
        rx_data_i = '0;
        rx_v_i = 1'b0;
        rx_last_i = 1'b0;
        rx_err_i = 1'b0;
        write_slot_ready_and_i = 1'b1;
        first_data = '0;
        last_data = '0;
        last_addr = '0;
        fork monitor(); join_none
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", {63'd0, rx_ready_o}, 64'd1);
        check("reset_strobes", {61'd0, write_v_o, write_size_v_o, write_slot_v_o}, 64'd0);
        check("reset_size", {48'd0, write_size_o}, 64'd0);
        check("reset_addr_data", write_data_o | {53'd0, write_addr_o}, 64'd0);
        check("reset_drop", {48'd0, drop_count_o}, 64'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        send_frame(60, 1'b0, 1'b1, 8'h00, 0, 0);
        settle();
        check("f60_writes", 64'(wr_count), 64'd8);
        check("f60_word0", first_data, 64'h0706050403020100);
        check("f60_last", last_data, 64'h000000003B3A3938);
        check("f60_last_addr", {53'd0, last_addr}, 64'h38);

        send_frame(1, 1'b0, 1'b1, 8'hAB, 0, 0);
        check("flush_ready", {63'd0, rx_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        check("commit_ready", {63'd0, rx_ready_o}, 64'd0);
        @(posedge clk_i); #1;
        check("idle_ready", {63'd0, rx_ready_o}, 64'd1);
        settle();
        check("f1_data", last_data, 64'h00000000000000AB);

        send_frame(17, 1'b1, 1'b1, 8'h40, 0, 0);
        settle();
        check("err_writes", 64'(wr_count), 64'd3);

        send_frame(100, 1'b0, 1'b0, 8'h10, 0, 0);
        settle();
        check("noslot_writes", 64'(wr_count), 64'd0);
        send_frame(12, 1'b0, 1'b1, 8'hC0, 0, 0);
        settle();

        send_frame(ELS, 1'b0, 1'b1, 8'h05, 0, 0);
        settle();
        check("max_writes", 64'(wr_count), 64'd256);

        send_frame(ELS + 1, 1'b0, 1'b1, 8'h07, 0, 0);
        settle();
        check("over_writes", 64'(wr_count), 64'd256);
        check("over_last_addr", {53'd0, last_addr}, 64'h7F8);

        send_frame(1, 1'b0, 1'b0, 8'h33, 0, 0);
        settle();

        send_frame(20, 1'b0, 1'b1, 8'h60, 0, 20);
        #2;
        reset_i = 1'b1;
        exp_drop = 0;
        #1;
        check("rst_strobes", {61'd0, write_v_o, write_size_v_o, write_slot_v_o}, 64'd0);
        check("rst_drop", {48'd0, drop_count_o}, 64'd0);
        check("rst_ready", {63'd0, rx_ready_o}, 64'd1);
        check("rst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #3;
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        send_frame(8, 1'b0, 1'b1, 8'h80, 3, 0);
        settle();
        check("gap8_writes", 64'(wr_count), 64'd1);
        send_frame(21, 1'b0, 1'b1, 8'hF0, 2, 0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rx_frame_writer.md
Name: rx_frame_writer

Overview:
- MAC-side producer for the rx slot buffer memory.
- Accepts the received-frame byte stream from the 1G MAC, one byte per beat.
- Packs bytes little-endian into data_width_p-bit words and writes them word-aligned into the current write slot.
- On a good end-of-frame, writes the frame byte count and commits the slot. Errored, oversize or slot-less frames are discarded and counted.

Parameters:
- data_width_p, 64, buffer word width; only 32 and 64 are legal.
- els_p, 2048, slot capacity in bytes, and therefore the maximum committed frame length.
- size_width_p, 16, width of the frame-size and drop-counter fields.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous active-high.
- rx_data_i  in  8  frame byte.
- rx_v_i  in  1  byte valid.
- rx_last_i  in  1  last byte of frame; qualified by rx_v_i.
- rx_err_i  in  1  frame error (bad FCS or PHY error); sampled only with rx_last_i.
- rx_ready_o  out  1  byte accepted when rx_v_i & rx_ready_o.
- write_slot_v_o  out  1  commit current slot.
- write_slot_ready_and_i  in  1  a free slot exists.
- write_size_v_o  out  1  write_size_o valid.
- write_size_o  out  size_width_p  committed frame length in bytes.
- write_v_o  out  1  word write strobe.
- write_addr_o  out  clog2(els_p)  byte address of word; low clog2(data_width_p/8) bits are always 0.
- write_data_o  out  data_width_p  packed word.
- drop_count_o  out  size_width_p  saturating count of discarded frames.

Behaviour:
- Reset values: all outputs 0, except rx_ready_o = 1 (state IDLE). Internals cleared: byte counter, pack register, drop counter.
- Reset asserted mid-frame: the partial frame is abandoned with no commit and no drop count. The first byte after reset deasserts starts a new frame.
- Derived sizes: W = data_width_p/8 bytes per word; lane = byte_cnt mod W. Byte k of a frame goes to bits [8*(k mod W) +: 8] of word k/W.
- FSM state IDLE (rx_ready_o = 1), on an accepted byte:
  - write_slot_ready_and_i = 1 → store byte at lane 0, byte_cnt = 1, go RECV.
  - write_slot_ready_and_i = 0 → go DROP, or, if rx_last_i is set on that byte, stay IDLE and increment the drop counter.
  - In either case a byte that is both first and last is handled per the RECV last-byte rules below.
- RECV (rx_ready_o = 1), per accepted byte:
  - Store the byte at the current lane and increment byte_cnt.
  - If the lane was W-1, or rx_last_i = 1: on the next cycle drive write_v_o = 1, write_addr_o = word_start_addr, write_data_o = packed word. Lanes not written are 0. Clear the pack register.
  - If byte_cnt would exceed els_p: do not store or write; go DROP, or go IDLE with drop+1 if rx_last_i is set.
- Last byte with rx_err_i = 1: emit the final word write, then go IDLE with drop+1. No size or slot strobe.
- Last byte with rx_err_i = 0: go FLUSH.
- FLUSH (rx_ready_o = 0): this cycle carries the final write_v_o. Then go COMMIT.
- COMMIT (rx_ready_o = 0): write_size_v_o = 1 and write_slot_v_o = 1 together for exactly one cycle, with write_size_o = byte_cnt (1..els_p). Then go IDLE.
  - write_slot_ready_and_i is guaranteed 1 here, because only this block enqueues. Sampling 0 is an assertion error.
- DROP (rx_ready_o = 1): bytes are consumed and discarded with no writes. On the byte with rx_last_i, increment the drop counter and go IDLE.
- Throughput:
  - One byte per cycle; rx_v_i may deassert at any cycle inside a frame.
  - Word writes are one cycle after the filling byte.
  - The end-of-frame gap is 2 cycles with rx_ready_o = 0. This is well inside the 12-byte Ethernet inter-frame gap.
- drop_count_o saturates at all-ones and is never cleared except by reset.
- Assertions (translate_off): data_width_p is 32 or 64; write_addr_o is aligned whenever write_v_o is set; write_size_o is nonzero whenever write_size_v_o is set.

Test Plan:
- 64-bit, 60-byte good frame, bytes 0x00..0x3B back-to-back → 8 writes at addresses 0x000..0x038.
  - Word 0 = 0x0706050403020100; last word = 0x000000003B3A3938.
  - One cycle after that write: write_size_o = 60 with size_v and slot_v high for one cycle.
- 1-byte frame 0xAB with last → write addr 0, data 0x00000000000000AB; next cycle commit with size 1.
- 17-byte frame with rx_err_i = 1 on last → 3 word writes, no size or slot strobe, drop_count_o = 1.
- write_slot_ready_and_i = 0 at frame start, 100-byte frame → no writes, drop_count_o increments by 1. The next frame, started with ready = 1, commits normally.
- Boundary lengths:
  - 2048-byte frame → 256 writes, commit size 2048.
  - 2049-byte frame → writes stop after address 0x7F8, no commit, drop+1.
- Async reset pulsed mid-frame after 20 bytes → outputs 0 immediately. The following 8-byte frame commits with size 8 at address 0. rx_v_i gaps inside a frame produce the same words as a gap-free run.
